// File: rtl/led_update_scheduler.sv
// Shares the serial LED driver among lamp-test, host and status frames. A driver update is
// issued only when the selected frame changes or a periodic refresh falls due.
module led_update_scheduler #(
  parameter int unsigned WIDTH            = 24,
  parameter int unsigned REFRESH_DIV      = 1000000,
  parameter int unsigned LAMP_TEST_CYCLES = 500000,
  parameter int unsigned RDY_TIMEOUT      = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] STATUS_DATA,
  input  logic             HOST_OVERRIDE,
  input  logic             HOST_VALID,
  input  logic [WIDTH-1:0] HOST_DATA,
  output logic             HOST_READY,
  input  logic             LAMP_TEST_REQ,
  input  logic             DRV_RDY,
  output logic             DRV_GO,
  output logic [WIDTH-1:0] DRV_DATA,
  output logic             BUSY,
  output logic [15:0]      FRAME_CNT
);

  localparam int unsigned LampW = (LAMP_TEST_CYCLES > 1) ? $clog2(LAMP_TEST_CYCLES + 1) : 1;
  localparam int unsigned RefW  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ToW   = (RDY_TIMEOUT > 2) ? $clog2(RDY_TIMEOUT) : 1;
  localparam logic [LampW-1:0] LampLoad = LampW'(LAMP_TEST_CYCLES);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitLow, StWaitHigh, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] host_q;
  logic [WIDTH-1:0] last_q;
  logic [LampW-1:0] lamp_q;
  logic [RefW-1:0]  refresh_q;
  logic [ToW-1:0]   to_q;
  logic             force_q;
  logic [WIDTH-1:0] sel;
  logic             refresh_due;
  logic             pending;

  always_comb begin
    sel = STATUS_DATA;
    if (lamp_q != '0) begin
      sel = '1;
    end else if (HOST_OVERRIDE) begin
      sel = host_q;
    end
  end

  assign refresh_due = (REFRESH_DIV != 0) && (32'(refresh_q) >= REFRESH_DIV - 1);
  assign pending     = force_q | refresh_due | (sel != last_q);
  assign BUSY        = (state_q != StIdle);
  assign HOST_READY  = RST_N && (state_q == StIdle);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      DRV_GO    <= 1'b0;
      DRV_DATA  <= '0;
      FRAME_CNT <= '0;
      host_q    <= '0;
      last_q    <= '0;
      lamp_q    <= '0;
      refresh_q <= '0;
      to_q      <= '0;
      force_q   <= 1'b1;
    end else begin
      if (LAMP_TEST_REQ) begin
        lamp_q <= LampLoad;
      end else if (lamp_q != '0) begin
        lamp_q <= lamp_q - 1'b1;
      end
      if (HOST_VALID && HOST_READY) begin
        host_q <= HOST_DATA;
      end
      DRV_GO <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pending && DRV_RDY) begin
            state_q   <= StIssue;
            DRV_DATA  <= sel;
            DRV_GO    <= 1'b1;
            force_q   <= 1'b0;
            refresh_q <= '0;
          end else if ((REFRESH_DIV != 0) && !refresh_due) begin
            // Saturates at the due value while the driver holds us off.
            refresh_q <= refresh_q + 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWaitLow;
          to_q    <= '0;
        end
        StWaitLow: begin
          if (!DRV_RDY) begin
            state_q <= StWaitHigh;
          end else if (32'(to_q) + 1 >= RDY_TIMEOUT) begin
            // RDY never dropped: driver finished within a cycle, count it as shifted.
            state_q <= StDone;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StWaitHigh: begin
          if (DRV_RDY) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          last_q    <= DRV_DATA;
          FRAME_CNT <= FRAME_CNT + 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_update_scheduler.sv
// Directed bench for led_update_scheduler: a driver model that drops RDY for 10 cycles after
// GO, plus a second instance with refresh disabled and RDY stuck high.
module tb_led_update_scheduler;

  localparam int unsigned W = 24;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [W-1:0] STATUS_DATA;
  logic         HOST_OVERRIDE;
  logic         HOST_VALID;
  logic [W-1:0] HOST_DATA;
  logic         LAMP_TEST_REQ;
  logic         drv_rdy;
  logic         HOST_READY, DRV_GO, BUSY;
  logic [W-1:0] DRV_DATA;
  logic [15:0]  FRAME_CNT;
  logic         hr2, go2, busy2;
  logic [W-1:0] data2;
  logic [15:0]  fc2;

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;
  int busy_cnt = 0;

  always #5 CLK = ~CLK;

  led_update_scheduler #(
    .WIDTH(W), .REFRESH_DIV(64), .LAMP_TEST_CYCLES(16), .RDY_TIMEOUT(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .STATUS_DATA(STATUS_DATA), .HOST_OVERRIDE(HOST_OVERRIDE),
    .HOST_VALID(HOST_VALID), .HOST_DATA(HOST_DATA), .HOST_READY(HOST_READY),
    .LAMP_TEST_REQ(LAMP_TEST_REQ), .DRV_RDY(drv_rdy), .DRV_GO(DRV_GO), .DRV_DATA(DRV_DATA),
    .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
  );

  led_update_scheduler #(
    .WIDTH(W), .REFRESH_DIV(0), .LAMP_TEST_CYCLES(16), .RDY_TIMEOUT(4)
  ) dut_norefresh (
    .CLK(CLK), .RST_N(RST_N), .STATUS_DATA(STATUS_DATA), .HOST_OVERRIDE(HOST_OVERRIDE),
    .HOST_VALID(HOST_VALID), .HOST_DATA(HOST_DATA), .HOST_READY(hr2),
    .LAMP_TEST_REQ(LAMP_TEST_REQ), .DRV_RDY(1'b1), .DRV_GO(go2), .DRV_DATA(data2),
    .BUSY(busy2), .FRAME_CNT(fc2)
  );

  // Driver model: RDY low for 10 cycles after each GO.
  always_ff @(posedge CLK) begin
    if (DRV_GO) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign drv_rdy = (busy_cnt == 0);

  typedef struct {
    logic [W-1:0] status;
    logic         ovr;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_go(input int max, output int k);
    k = -1;
    for (int i = 1; i <= max && k < 0; i++) begin
      @(negedge CLK);
      if (DRV_GO) k = i;
    end
  endtask

  task automatic wait_idle_hold(input logic [W-1:0] exp, input int max, output int k,
                                output bit stable);
    k = -1;
    stable = 1'b1;
    for (int i = 1; i <= max && k < 0; i++) begin
      @(negedge CLK);
      if (!BUSY) k = i;
      else if (DRV_DATA !== exp) stable = 1'b0;
    end
  endtask

  task automatic lamp_watch(input int retrig_k, output int k_ones, output int k_host,
                            output int n_go);
    k_ones = -1;
    k_host = -1;
    n_go = 0;
    for (int k = 1; k <= 40 && k_host < 0; k++) begin
      @(negedge CLK);
      LAMP_TEST_REQ = (k == retrig_k);
      if (DRV_GO) begin
        n_go++;
        if (DRV_DATA == 24'hFFFFFF && k_ones < 0) k_ones = k;
        if (DRV_DATA == 24'h123456) k_host = k;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int k, k1, k2, n, k_main, k_go2, k_fc2, n_main;
    bit st;
    logic [W-1:0] d_main;

    vecs[0] = '{24'h000001, 1'b0, 24'h000001};
    vecs[1] = '{24'h0A0F03, 1'b0, 24'h0A0F03};
    vecs[2] = '{24'h5A5A5A, 1'b0, 24'h5A5A5A};
    vecs[3] = '{24'hFFFFFE, 1'b0, 24'hFFFFFE};
    vecs[4] = '{24'h000123, 1'b1, 24'h000000};  // host_reg still 0 from reset
    vecs[5] = '{24'h777777, 1'b0, 24'h777777};

    RST_N = 1'b0; STATUS_DATA = '0; HOST_OVERRIDE = 1'b0; HOST_VALID = 1'b0;
    HOST_DATA = '0; LAMP_TEST_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_go", 32'(DRV_GO), 0);
    chk("rst_data", 32'(DRV_DATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_fcnt", 32'(FRAME_CNT), 0);
    chk("rst_ready", 32'(HOST_READY), 0);
    chk("rst_ready2", 32'(hr2), 0);
    chk("rst_busy2", 32'(busy2), 0);

    RST_N = 1'b1;
    @(negedge CLK);
    chk("first_go", 32'(DRV_GO), 1);
    chk("first_data", 32'(DRV_DATA), 0);
    wait_idle_hold(24'h0, 40, k, st);
    exp_fc = 1;
    chk("first_fcnt", 32'(FRAME_CNT), 32'(exp_fc));
    wait_go(100, k);
    chk("refresh_interval", 32'(k), 64);
    chk("refresh_data", 32'(DRV_DATA), 0);
    wait_idle_hold(24'h0, 40, k, st);
    exp_fc = 2;
    chk("refresh_fcnt", 32'(FRAME_CNT), 32'(exp_fc));

    for (int i = 0; i < 6; i++) begin
      STATUS_DATA = vecs[i].status;
      HOST_OVERRIDE = vecs[i].ovr;
      wait_go(3, k);
      chk($sformatf("vec%0d_latency", i), 32'(k), 1);
      chk($sformatf("vec%0d_data", i), 32'(DRV_DATA), 32'(vecs[i].exp));
      wait_idle_hold(vecs[i].exp, 40, k, st);
      exp_fc++;
      chk($sformatf("vec%0d_hold", i), 32'(st), 1);
      chk($sformatf("vec%0d_fcnt", i), 32'(FRAME_CNT), 32'(exp_fc));
    end

    // Source change while shifting is caught by the next idle compare.
    STATUS_DATA = 24'h000001;
    wait_go(3, k);
    chk("mid_go1", 32'(DRV_DATA), 32'h000001);
    repeat (3) @(negedge CLK);
    STATUS_DATA = 24'h000002;
    wait_idle_hold(24'h000001, 40, k, st);
    chk("mid_hold", 32'(st), 1);
    wait_go(5, k);
    chk("mid_go2_gap", 32'(k), 1);
    chk("mid_go2_data", 32'(DRV_DATA), 32'h000002);
    wait_idle_hold(24'h000002, 40, k, st);
    exp_fc += 2;
    chk("mid_fcnt", 32'(FRAME_CNT), 32'(exp_fc));

    // Lamp request and host write in the same cycle; lamp wins selection.
    LAMP_TEST_REQ = 1'b1; HOST_VALID = 1'b1; HOST_DATA = 24'h123456;
    chk("host_ready_idle", 32'(HOST_READY), 1);
    @(negedge CLK);
    LAMP_TEST_REQ = 1'b0; HOST_VALID = 1'b0; HOST_OVERRIDE = 1'b1;
    lamp_watch(0, k1, k2, n);
    chk("lamp1_ones_at", 32'(k1), 1);
    chk("lamp1_host_at", 32'(k2), 17);
    chk("lamp1_gos", 32'(n), 2);
    wait_idle_hold(24'h123456, 40, k, st);
    exp_fc += 2;
    chk("lamp1_fcnt", 32'(FRAME_CNT), 32'(exp_fc));

    // Retrigger at cycle 10 extends the lamp frame.
    LAMP_TEST_REQ = 1'b1;
    @(negedge CLK);
    LAMP_TEST_REQ = 1'b0;
    lamp_watch(9, k1, k2, n);
    chk("lamp2_ones_at", 32'(k1), 1);
    chk("lamp2_host_at", 32'(k2), 27);
    chk("lamp2_gos", 32'(n), 2);

    // Host write while busy is dropped; held until idle it is accepted.
    HOST_VALID = 1'b1; HOST_DATA = 24'hABCDEF;
    @(negedge CLK);
    chk("host_ready_busy", 32'(HOST_READY), 0);
    wait_idle_hold(24'h123456, 40, k, st);
    exp_fc += 2;
    chk("host_hold", 32'(st), 1);
    chk("host_fcnt1", 32'(FRAME_CNT), 32'(exp_fc));
    chk("host_ready_back", 32'(HOST_READY), 1);
    wait_go(5, k);
    chk("host_go_at", 32'(k), 2);
    chk("host_go_data", 32'(DRV_DATA), 32'hABCDEF);
    HOST_VALID = 1'b0;
    wait_idle_hold(24'hABCDEF, 40, k, st);
    exp_fc++;
    chk("host_fcnt2", 32'(FRAME_CNT), 32'(exp_fc));

    // Reset during WAIT_HIGH abandons the shift; a forced frame follows.
    HOST_OVERRIDE = 1'b0;
    wait_go(3, k);
    chk("pre_rst_data", 32'(DRV_DATA), 32'h000002);
    repeat (4) @(negedge CLK);
    chk("pre_rst_busy", 32'(BUSY), 1);
    RST_N = 1'b0; STATUS_DATA = '0;
    @(negedge CLK);
    chk("midrst_go", 32'(DRV_GO), 0);
    chk("midrst_fcnt", 32'(FRAME_CNT), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_data", 32'(DRV_DATA), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    k_main = -1; k_go2 = -1; k_fc2 = -1; n_main = 0; d_main = 24'h555555;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (DRV_GO) begin
        n_main++;
        if (k_main < 0) begin k_main = i; d_main = DRV_DATA; end
      end
      if (go2 && k_go2 < 0) k_go2 = i;
      if (fc2 == 16'd1 && k_fc2 < 0) k_fc2 = i;
    end
    chk("force_go_at", 32'(k_main), 6);
    chk("force_go_data", 32'(d_main), 0);
    chk("force_go_count", 32'(n_main), 1);
    chk("force_fcnt", 32'(FRAME_CNT), 1);
    chk("timeout_go_at", 32'(k_go2), 1);
    chk("timeout_go_data", 32'(data2), 0);
    chk("timeout_done_at", 32'(k_fc2), 7);

    // Refresh disabled: static input gives no further GO.
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (go2) n++;
    end
    chk("norefresh_gos", 32'(n), 0);
    chk("norefresh_fcnt", 32'(fc2), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_update_scheduler.md
Name: led_update_scheduler

Overview:
- Sequences the serial LED shift-register driver (LED_Driver GO/RDY/DATA interface) and shares it among three frame sources: lamp test, host override and live status.
- Issues a driver update only when the selected frame changes, or when a periodic refresh falls due.
- Guarantees single-cycle GO pulses and a stable DRV_DATA for the whole shift.
- Sits between the front-panel status logic and LED_Driver; runs in the driver's 1 MHz domain.

Parameters:
- WIDTH, 24, frame width in bits; DRV_DATA is already in panel bit order.
- REFRESH_DIV, 1000000, idle cycles between forced refreshes; 0 disables refresh.
- LAMP_TEST_CYCLES, 500000, duration of the all-ones lamp test frame.
- RDY_TIMEOUT, 4, cycles allowed for DRV_RDY to drop after GO.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- STATUS_DATA  in  WIDTH  live status frame (trigger mask / mux LEDs).
- HOST_OVERRIDE  in  1  level; selects the host frame over status.
- HOST_VALID  in  1  host frame write strobe.
- HOST_DATA  in  WIDTH  host frame.
- HOST_READY  out  1  host frame accepted this cycle if HOST_VALID.
- LAMP_TEST_REQ  in  1  start/retrigger lamp test.
- DRV_RDY  in  1  driver idle.
- DRV_GO  out  1  one-cycle start pulse to the driver.
- DRV_DATA  out  WIDTH  frame to the driver.
- BUSY  out  1  shift in progress (state != IDLE).
- FRAME_CNT  out  16  completed updates; wraps 0xFFFF->0.

Behaviour:
- Reset (RST_N=0 at an edge):
  - Outputs: DRV_GO=0, DRV_DATA=0, BUSY=0, FRAME_CNT=0, HOST_READY=0.
  - Internal: host_reg=0, lamp_cnt=0, refresh_cnt=0, last_sent=0, force=1.
  - Reset mid-shift abandons the shift; force=1 guarantees a fresh frame after reset.
- Source select (combinational, priority):
  - lamp_cnt!=0 -> all ones.
  - else HOST_OVERRIDE=1 -> host_reg.
  - else STATUS_DATA.
- Lamp test:
  - LAMP_TEST_REQ=1 at an edge loads lamp_cnt=LAMP_TEST_CYCLES; re-asserting reloads it (retrigger).
  - Otherwise lamp_cnt decrements to 0 and saturates there.
- Host port:
  - HOST_READY=1 exactly when state==IDLE and not in reset.
  - HOST_VALID&HOST_READY loads host_reg next edge.
  - HOST_VALID while not ready is dropped; the host must hold it.
- Refresh:
  - refresh_cnt increments in IDLE and clears on every GO.
  - refresh_due = (REFRESH_DIV!=0) && refresh_cnt>=REFRESH_DIV-1.
- pending = force | refresh_due | (sel != last_sent).
- FSM:
  - IDLE: if pending && DRV_RDY -> ISSUE. Latch DRV_DATA<=sel, assert DRV_GO=1 for exactly the next cycle, clear force.
  - ISSUE (1 cycle, DRV_GO=1): -> WAIT_LOW; clear the timeout counter.
  - WAIT_LOW: DRV_RDY=0 -> WAIT_HIGH. If RDY_TIMEOUT cycles pass with RDY still 1, treat the shift as complete (instant driver) -> DONE.
  - WAIT_HIGH: DRV_RDY=1 -> DONE.
  - DONE (1 cycle): last_sent<=DRV_DATA, FRAME_CNT+=1 -> IDLE.
- Hold rules: DRV_DATA is stable from ISSUE through DONE; source changes during a shift are not lost, because the next IDLE compare catches them.
- Latency:
  - Source change in IDLE with DRV_RDY=1 -> DRV_GO asserted 1 cycle later.
  - Back-to-back frames are separated by at least 2 cycles of DRV_GO=0 (DONE + IDLE).
- Simultaneous events:
  - Lamp test request and host write in the same cycle: both take effect; the lamp frame wins selection.
  - Refresh and change in the same cycle: one update only.
- DRV_RDY=0 in IDLE: hold; no GO.
- refresh_cnt saturates at REFRESH_DIV-1 while the driver is held off.

Test Plan:
- Driver model RDY low 10 cycles after GO; REFRESH_DIV=64, LAMP_TEST_CYCLES=16; reset release with STATUS_DATA=0 -> one GO 1 cycle after first IDLE, DRV_DATA=0, FRAME_CNT=1, then no GO until refresh at ~64 idle cycles.
- STATUS_DATA 0x000001 -> 0x0A0F03 in IDLE -> DRV_GO one cycle later, DRV_DATA=0x0A0F03 held until RDY rises; STATUS change mid-shift to 0x000002 -> second GO after DONE, FRAME_CNT +2 total.
- LAMP_TEST_REQ pulse with HOST_OVERRIDE=1 and host_reg=0x123456 -> frame 0xFFFFFF sent; after 16 cycles 0x123456 sent; retrigger at cycle 10 extends to cycle 26.
- HOST_VALID with 0xABCDEF during a shift (HOST_READY=0) -> dropped; held until IDLE -> accepted; with override=1, GO with 0xABCDEF.
- Driver never drops RDY -> timeout after 4 cycles, DONE, FRAME_CNT increments, no lockup; REFRESH_DIV=0 -> no GO for 1000 cycles with static input.
- RST_N low during WAIT_HIGH -> next edge DRV_GO=0, FRAME_CNT=0, BUSY=0; after release a forced frame is issued.
